// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM encoding, hazard priority, M-extension decode constants.
// The instruction decoder imports the same package.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } hz_state_e;

    // Ordered lowest to highest priority.
    typedef enum logic [2:0] {
        PRIO_NONE,
        PRIO_LOAD_USE,
        PRIO_MULDIV,
        PRIO_REDIRECT,
        PRIO_BUSYWAIT
    } hz_prio_e;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    function automatic logic is_muldiv(input logic [6:0] opcode, input logic [6:0] funct7);
        return (opcode == OPC_OP) && (funct7 == F7_MULDIV);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: datapath status into the controller, stall/flush controls and counters out.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             BUSYWAIT;
    logic [4:0]       ID_RS1;
    logic [4:0]       ID_RS2;
    logic             ID_USE_RS1;
    logic             ID_USE_RS2;
    logic [4:0]       EX_RD;
    logic             EX_MEMREAD;
    logic             EX_REDIRECT;
    logic             EX_MULDIV;
    logic             EX_IS_DIV;
    logic             PC_STALL;
    logic             IFID_STALL;
    logic             IFID_FLUSH;
    logic             IDEX_STALL;
    logic             IDEX_FLUSH;
    logic             EXMEM_STALL;
    logic             EXMEM_FLUSH;
    logic             MEMWB_STALL;
    logic             MULDIV_BUSY;
    logic [CNT_W-1:0] STALL_CNT;
    logic [CNT_W-1:0] FLUSH_CNT;

    modport master (
        output BUSYWAIT, ID_RS1, ID_RS2, ID_USE_RS1, ID_USE_RS2,
               EX_RD, EX_MEMREAD, EX_REDIRECT, EX_MULDIV, EX_IS_DIV,
        input  PC_STALL, IFID_STALL, IFID_FLUSH, IDEX_STALL, IDEX_FLUSH,
               EXMEM_STALL, EXMEM_FLUSH, MEMWB_STALL, MULDIV_BUSY,
               STALL_CNT, FLUSH_CNT
    );

    modport slave (
        input  BUSYWAIT, ID_RS1, ID_RS2, ID_USE_RS1, ID_USE_RS2,
               EX_RD, EX_MEMREAD, EX_REDIRECT, EX_MULDIV, EX_IS_DIV,
        output PC_STALL, IFID_STALL, IFID_FLUSH, IDEX_STALL, IDEX_FLUSH,
               EXMEM_STALL, EXMEM_FLUSH, MEMWB_STALL, MULDIV_BUSY,
               STALL_CNT, FLUSH_CNT
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module pipeline_hazard_ctrl_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (RESET)
            r_cnt <= '0;
        else if (i_inc && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush controller: memory freeze, redirect flush, MUL/DIV occupancy and load-use bubbles.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 32
) (
    input  logic                 CLK,
    input  logic                 RESET,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int MD_MAX = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int MD_W   = $clog2(MD_MAX + 1);
    localparam logic [MD_W-1:0] MUL_N1 = MD_W'(MUL_CYCLES - 1);
    localparam logic [MD_W-1:0] DIV_N1 = MD_W'(DIV_CYCLES - 1);
    localparam logic            MUL_LONG = (MUL_CYCLES > 1);
    localparam logic            DIV_LONG = (DIV_CYCLES > 1);

    hz_state_e       r_state, w_state_nxt;
    logic [MD_W-1:0] r_md_cnt, w_md_cnt_nxt;
    hz_prio_e        w_prio;
    logic            w_load_use;
    logic            w_md_long;

    assign w_load_use = hz.EX_MEMREAD && (hz.EX_RD != 5'd0) &&
                        ((hz.ID_USE_RS1 && (hz.ID_RS1 == hz.EX_RD)) ||
                         (hz.ID_USE_RS2 && (hz.ID_RS2 == hz.EX_RD)));
    assign w_md_long  = hz.EX_IS_DIV ? DIV_LONG : MUL_LONG;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= ST_RUN;
            r_md_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
        end
    end

    // An ongoing MUL/DIV wait outranks a redirect: nothing else can be in EX meanwhile.
    always_comb begin
        w_prio = PRIO_NONE;
        if (hz.BUSYWAIT)
            w_prio = PRIO_BUSYWAIT;
        else if (r_state == ST_MD_WAIT)
            w_prio = PRIO_MULDIV;
        else if (hz.EX_REDIRECT)
            w_prio = PRIO_REDIRECT;
        else if (hz.EX_MULDIV && w_md_long)
            w_prio = PRIO_MULDIV;
        else if (w_load_use)
            w_prio = PRIO_LOAD_USE;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;
        if (r_state == ST_MD_WAIT) begin
            if (!hz.BUSYWAIT) begin
                if (r_md_cnt == MD_W'(1)) begin
                    w_state_nxt  = ST_RUN;
                    w_md_cnt_nxt = '0;
                end else begin
                    w_md_cnt_nxt = r_md_cnt - 1'b1;
                end
            end
        end else if (w_prio == PRIO_MULDIV) begin
            w_state_nxt  = ST_MD_WAIT;
            w_md_cnt_nxt = hz.EX_IS_DIV ? DIV_N1 : MUL_N1;
        end
    end

    always_comb begin
        hz.PC_STALL    = 1'b0;
        hz.IFID_STALL  = 1'b0;
        hz.IFID_FLUSH  = 1'b0;
        hz.IDEX_STALL  = 1'b0;
        hz.IDEX_FLUSH  = 1'b0;
        hz.EXMEM_STALL = 1'b0;
        hz.EXMEM_FLUSH = 1'b0;
        hz.MEMWB_STALL = 1'b0;
        hz.MULDIV_BUSY = !RESET && (r_state == ST_MD_WAIT);
        if (!RESET) begin
            case (w_prio)
                PRIO_BUSYWAIT: begin
                    hz.PC_STALL    = 1'b1;
                    hz.IFID_STALL  = 1'b1;
                    hz.IDEX_STALL  = 1'b1;
                    hz.EXMEM_STALL = 1'b1;
                    hz.MEMWB_STALL = 1'b1;
                end
                PRIO_REDIRECT: begin
                    hz.IFID_FLUSH = 1'b1;
                    hz.IDEX_FLUSH = 1'b1;
                end
                // MEM/WB keeps moving so older instructions drain past the busy EX.
                PRIO_MULDIV: begin
                    hz.PC_STALL    = 1'b1;
                    hz.IFID_STALL  = 1'b1;
                    hz.IDEX_STALL  = 1'b1;
                    hz.EXMEM_STALL = 1'b1;
                end
                PRIO_LOAD_USE: begin
                    hz.PC_STALL   = 1'b1;
                    hz.IFID_STALL = 1'b1;
                    hz.IDEX_FLUSH = 1'b1;
                end
                default: ;
            endcase
        end
    end

    pipeline_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .i_inc (hz.PC_STALL),
        .o_cnt (hz.STALL_CNT)
    );

    pipeline_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .i_inc (hz.IFID_FLUSH),
        .o_cnt (hz.FLUSH_CNT)
    );
endmodule
